// File: rtl/mem_arbiter_if.sv
// Main-memory port bundle between the arbiter and the memory model.
// master: drives strobe/address/write data; slave: returns read data.
interface mem_arbiter_if;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_data_valid;
  logic [15:0] mem_rdata;

  modport master (
    output mem_en,
    output mem_wr,
    output mem_addr,
    output mem_wdata,
    input  mem_data_valid,
    input  mem_rdata
  );

  modport slave (
    input  mem_en,
    input  mem_wr,
    input  mem_addr,
    input  mem_wdata,
    output mem_data_valid,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Main-memory arbiter: store > D-fill > I-fill, 8-beat block fills.
// Ports: clk/rst_n, I/D miss + store requests, mem bus, fill beats out.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_miss_i,
  input  logic [15:0] i_addr_i,
  input  logic        d_miss_i,
  input  logic [15:0] d_addr_i,
  input  logic        d_wr_req_i,
  input  logic [15:0] d_wr_addr_i,
  input  logic [15:0] d_wr_data_i,
  mem_arbiter_if.master mem,
  output logic [15:0] rdata_o,
  output logic [2:0]  rbeat_o,
  output logic        i_valid_o,
  output logic        d_valid_o,
  output logic        i_done_o,
  output logic        d_done_o,
  output logic        d_wr_ack_o
);
  localparam logic [3:0] BEATS = 4'd8;

  typedef enum logic [1:0] {
    IDLE, WRITE, D_FILL, I_FILL
  } state_e;

  state_e      state_q;
  logic [3:0]  iss_q;
  logic [3:0]  ret_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;

  logic fill;
  logic issuing;
  logic beat;
  logic done;

  // Fills always start on a 16-byte boundary.
  logic unused_addr_lo;
  assign unused_addr_lo = ^{i_addr_i[3:0], d_addr_i[3:0]};

  assign fill    = (state_q == D_FILL) || (state_q == I_FILL);
  assign issuing = fill && (iss_q < BEATS);
  assign beat    = fill && mem.mem_data_valid && (ret_q < BEATS);
  assign done    = beat && (ret_q == BEATS - 4'd1);

  always_comb begin
    mem.mem_en    = 1'b0;
    mem.mem_wr    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    unique case (1'b1)
      state_q == WRITE: begin
        mem.mem_en    = 1'b1;
        mem.mem_wr    = 1'b1;
        mem.mem_addr  = addr_q;
        mem.mem_wdata = wdata_q;
      end
      issuing: begin
        mem.mem_en   = 1'b1;
        // Word offset lives in bits 3:1 only; no carry out.
        mem.mem_addr = {addr_q[15:4], iss_q[2:0], 1'b0};
      end
      default: ;
    endcase
  end

  assign rdata_o    = beat ? mem.mem_rdata : '0;
  assign rbeat_o    = beat ? ret_q[2:0] : '0;
  assign i_valid_o  = beat && (state_q == I_FILL);
  assign d_valid_o  = beat && (state_q == D_FILL);
  assign i_done_o   = done && (state_q == I_FILL);
  assign d_done_o   = done && (state_q == D_FILL);
  assign d_wr_ack_o = (state_q == WRITE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      iss_q   <= '0;
      ret_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          iss_q <= '0;
          ret_q <= '0;
          if (d_wr_req_i) begin
            state_q <= WRITE;
            addr_q  <= d_wr_addr_i;
            wdata_q <= d_wr_data_i;
          end else if (d_miss_i) begin
            state_q <= D_FILL;
            addr_q  <= {d_addr_i[15:4], 4'h0};
          end else if (i_miss_i) begin
            state_q <= I_FILL;
            addr_q  <= {i_addr_i[15:4], 4'h0};
          end
        end
        WRITE: state_q <= IDLE;
        default: begin
          if (issuing) iss_q <= iss_q + 4'd1;
          if (beat)    ret_q <= ret_q + 4'd1;
          if (done)    state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single main-memory port among the I-cache fill FSM, the D-cache fill FSM and D-cache write-through stores. It sits directly upstream of both cache fill FSMs and downstream of the memory model:
- it grants the port to one requester at a time;
- it generates the eight word addresses of a 16-byte block fill;
- it returns read data as indexed beats to the granted cache.

Writes are single-cycle; fills hold the port until every beat has returned.

## Interface
- BEATS, 8, words per block fill (16-bit words, 16-byte block)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_miss  in  1  I-cache fill request, level, held until i_done
- i_addr  in  16  I-cache miss byte address
- d_miss  in  1  D-cache fill request, level, held until d_done
- d_addr  in  16  D-cache miss byte address
- d_wr_req  in  1  D-cache write-through store request, level, held until d_wr_ack
- d_wr_addr  in  16  store byte address
- d_wr_data  in  16  store data
- mem_en  out  1  memory access strobe, one access per asserted cycle
- mem_wr  out  1  1 = write, 0 = read; qualified by mem_en
- mem_addr  out  16  memory byte address
- mem_wdata  out  16  write data
- mem_data_valid  in  1  read data return strobe from memory
- mem_rdata  in  16  read return data
- rdata  out  16  mem_rdata forwarded to caches
- rbeat  out  3  word index of the current returned beat
- i_valid  out  1  rdata/rbeat is an I-cache fill beat
- d_valid  out  1  rdata/rbeat is a D-cache fill beat
- i_done  out  1  one-cycle pulse, I-cache fill complete
- d_done  out  1  one-cycle pulse, D-cache fill complete
- d_wr_ack  out  1  one-cycle pulse, store issued

## Operation
- States: IDLE, WRITE, D_FILL, I_FILL.
- Priority: d_wr_req > d_miss > i_miss.
- IDLE:
  - Samples requests and moves to the winner's state on the next edge.
  - A fill latches the base address {addr[15:4],4'h0}.
  - WRITE latches d_wr_addr/d_wr_data.
- WRITE (1 cycle):
  - mem_en=1, mem_wr=1, mem_addr/mem_wdata = latched values, d_wr_ack=1.
  - Next state is IDLE.
- D_FILL / I_FILL:
  - Issue counter iss (0..BEATS) and return counter ret (0..BEATS), both cleared on entry.
  - While iss<BEATS: mem_en=1, mem_wr=0, mem_addr = base + (iss<<1), iss++ every cycle.
  - Each mem_data_valid: rdata=mem_rdata, rbeat=ret[2:0], granted-side *_valid=1, ret++.
  - When the BEATS-th valid arrives, the granted-side *_done=1 in the same cycle; next state is IDLE.
- The granted fill always completes, even if its miss request drops mid-fill. There is no abort.
- mem_data_valid in IDLE or WRITE is ignored: no *_valid, no counter change.
- mem_data_valid after ret==BEATS is ignored.
- Requests arriving during a grant wait. They are re-evaluated in IDLE after the grant completes.

## Timing
- Reset (async assert, synchronous release on clk):
  - State goes to IDLE; counters and latched address/data clear to 0.
  - All outputs are 0: mem_en, mem_wr, mem_addr, mem_wdata, rdata, rbeat, i_valid, d_valid, i_done, d_done, d_wr_ack.
- Reset mid-fill discards the fill. Data returning after reset release is ignored because the state is IDLE.
- Grant latency:
  - A request seen in IDLE at edge N produces the state change at edge N+1.
  - The first mem_en is in cycle N+1.
- Fill issue: cycles N+1..N+BEATS carry mem_en=1, addresses base+0, +2, …, +14.
- Fill completion: the done pulse coincides with the last valid beat. The state is IDLE the following cycle.
- Back-to-back requests: the minimum gap between two grants is one IDLE cycle.
- Output timing:
  - mem_en, mem_wr, mem_addr, mem_wdata decode combinationally from registered state and counters.
  - rdata, rbeat, *_valid, *_done decode combinationally from mem_data_valid/mem_rdata and registered state.
- Width rules:
  - base + (iss<<1) never carries past bit 3; the block is 16-byte aligned.
  - rbeat is ret mod 8.

## Test plan
- I-cache fill, memory latency 4:
  - Stimulus: i_miss=1, i_addr=16'h1236.
  - Response: mem_addr 16'h1230, 1232, …, 123E over 8 consecutive cycles.
  - Response: 8 i_valid beats with rbeat 0..7 and rdata matching memory.
  - Response: i_done with beat 7, then IDLE.
- Simultaneous requests:
  - Stimulus: d_wr_req, d_miss and i_miss all assert in the same cycle.
  - Response: write issued first (d_wr_ack, mem_wr=1), then the full D-cache fill (d_done), then the I-cache fill (i_done).
- Request arrives mid-fill:
  - Stimulus: d_miss asserts during an I-cache fill.
  - Response: the I-cache fill completes uninterrupted with no d_valid; D_FILL starts after one IDLE cycle.
- Miss deasserts mid-fill:
  - Stimulus: i_miss drops after beat 3.
  - Response: all 8 beats are still issued and returned; i_done pulses.
- Reset mid-fill:
  - Stimulus: rst_n pulled low after beat 2.
  - Response: all outputs 0 immediately.
  - Response: late mem_data_valid after release produces no *_valid and no *_done.
- Stray return:
  - Stimulus: mem_data_valid=1 while IDLE.
  - Response: i_valid=d_valid=0 and no state change.
